upsample_2x: RTL and testbench

UPSAMPLE_2X -- requirements
Module: upsample_2x

---
 rtl/cnn_stream_pkg.sv | 18 +
 rtl/upsample_linebuf.sv | 35 +++
 rtl/upsample_2x.sv | 245 ++++++++++++++++++++++++
 tb/tb_upsample_2x.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared constants and state encoding for the CNN streaming blocks.
package cnn_stream_pkg;

   localparam int UPS_DATA_W_DEF = 16;
   localparam int UPS_DEPTH_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_REPLAY = 2'd2
   } ups_state_e;

   // Address width for a buffer of the given depth (at least one bit).
   function automatic int ups_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/upsample_linebuf.sv
// Single-port synchronous line buffer, DEPTH x DATA_W.
// Active-low enable and write enable; read data is registered and holds
// its value until the next read.
module upsample_linebuf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              en_n,
   input  logic              we_n,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Read data only updates on an enabled read cycle.
   always_comb begin
      rdata_d = rdata_q;
      if (!en_n && we_n) rdata_d = mem_q[addr];
   end

   // Storage array and registered read port.
   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
      if (!en_n && !we_n) mem_q[addr] <= wdata;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/upsample_2x.sv
// 2x upsampler for a pooled pixel stream.
// Each input line is emitted live with every pixel doubled (FILL), then
// replayed once from the line buffer (REPLAY).
// Build option: UPSAMPLE_ZERO_INSERT_EN replaces every duplicated beat
// (phase 1 and all replayed beats) with zero; timing and markers unchanged.
//
// state  | meaning
// IDLE   | waiting for a frame-start beat, other beats dropped
// FILL   | accepting a line, each pixel stored and sent as two beats
// REPLAY | re-sending the stored line, each word sent as two beats
module upsample_2x
   import cnn_stream_pkg::*;
#(
   parameter int DATA_W = UPS_DATA_W_DEF,
   parameter int DEPTH  = UPS_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_frame_start,
   input  logic              in_line_end,
   input  logic              in_frame_end,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_frame_start,
   output logic              out_line_start,
   output logic              out_line_end,
   output logic              out_frame_end,
   output logic              err_overflow
);

   localparam int AW = ups_addr_w(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] A_ONE     = AW'(1);
   localparam logic [AW:0]   L_ONE     = (AW + 1)'(1);
`ifdef UPSAMPLE_ZERO_INSERT_EN
   localparam bit ZERO_INS = 1'b1;
`else
   localparam bit ZERO_INS = 1'b0;
`endif

   ups_state_e        state_q, state_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic [AW:0]       len_q, len_d;
   logic              phase_q, phase_d;
   logic              last_pix_q, last_pix_d;
   logic              fe_line_q, fe_line_d;
   logic              err_q, err_d;
   logic              rdy_en_q;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_fs_q, out_fs_d;
   logic              out_ls_q, out_ls_d;
   logic              out_le_q, out_le_d;
   logic              out_fe_q, out_fe_d;

   logic              buf_en_n, buf_we_n;
   logic [AW-1:0]     buf_addr;
   logic [DATA_W-1:0] buf_rdata;
   logic [DATA_W-1:0] rep_word;
   logic              in_ready_c, accept, adv, line_first, pix_last, rep_last;
   logic [AW-1:0]     pix_addr;
   logic [AW:0]       len_m1;

   upsample_linebuf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_linebuf (
      .clk   (clk),
      .en_n  (buf_en_n),
      .we_n  (buf_we_n),
      .addr  (buf_addr),
      .wdata (in_data),
      .rdata (buf_rdata)
   );

   // Next-state, output register and buffer port control.
   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      len_d       = len_q;
      phase_d     = phase_q;
      last_pix_d  = last_pix_q;
      fe_line_d   = fe_line_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_fs_d    = out_fs_q;
      out_ls_d    = out_ls_q;
      out_le_d    = out_le_q;
      out_fe_d    = out_fe_q;
      buf_en_n    = 1'b1;
      buf_we_n    = 1'b1;
      buf_addr    = wr_addr_q;
      in_ready_c  = 1'b0;
      accept      = 1'b0;

      adv        = !out_valid_q || out_ready;
      line_first = (wr_addr_q == '0) || in_frame_start;
      pix_addr   = line_first ? '0 : wr_addr_q;
      pix_last   = in_line_end || in_frame_end || (pix_addr == LAST_ADDR);
      len_m1     = len_q - L_ONE;
      rep_last   = (rd_addr_q == len_m1[AW-1:0]);
      rep_word   = ZERO_INS ? '0 : buf_rdata;

      case (state_q)
         ST_IDLE: begin
            in_ready_c = rdy_en_q;
            accept     = in_valid && rdy_en_q && in_frame_start;
         end
         ST_FILL: begin
            if (out_valid_q && !phase_q) begin
               if (out_ready) begin
                  out_data_d = ZERO_INS ? '0 : out_data_q;
                  out_fs_d   = 1'b0;
                  out_ls_d   = 1'b0;
                  out_le_d   = last_pix_q;
                  out_fe_d   = 1'b0;
                  phase_d    = 1'b1;
               end
            end else if (out_valid_q && last_pix_q) begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  out_le_d    = 1'b0;
                  state_d     = ST_REPLAY;
                  rd_addr_d   = '0;
                  buf_en_n    = ZERO_INS;
                  buf_addr    = '0;
               end
            end else begin
               in_ready_c = rdy_en_q && adv;
               accept     = in_valid && in_ready_c;
               if (!accept && adv) begin
                  out_valid_d = 1'b0;
                  out_fs_d    = 1'b0;
                  out_ls_d    = 1'b0;
                  out_le_d    = 1'b0;
                  out_fe_d    = 1'b0;
               end
            end
         end
         ST_REPLAY: begin
            if (!out_valid_q || (phase_q && out_ready && !last_pix_q)) begin
               out_valid_d = 1'b1;
               out_data_d  = rep_word;
               out_fs_d    = 1'b0;
               out_ls_d    = (rd_addr_q == '0);
               out_le_d    = 1'b0;
               out_fe_d    = 1'b0;
               phase_d     = 1'b0;
               last_pix_d  = 1'b0;
            end else if (!phase_q && out_ready) begin
               out_ls_d   = 1'b0;
               out_le_d   = rep_last;
               out_fe_d   = rep_last && fe_line_q;
               phase_d    = 1'b1;
               last_pix_d = rep_last;
               if (!rep_last) begin
                  rd_addr_d = rd_addr_q + A_ONE;
                  buf_en_n  = ZERO_INS;
                  buf_addr  = rd_addr_q + A_ONE;
               end
            end else if (phase_q && out_ready) begin
               out_valid_d = 1'b0;
               out_le_d    = 1'b0;
               out_fe_d    = 1'b0;
               wr_addr_d   = '0;
               rd_addr_d   = '0;
               state_d     = fe_line_q ? ST_IDLE : ST_FILL;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         buf_en_n    = 1'b0;
         buf_we_n    = 1'b0;
         buf_addr    = pix_addr;
         out_valid_d = 1'b1;
         out_data_d  = in_data;
         out_fs_d    = (state_q == ST_IDLE);
         out_ls_d    = line_first;
         out_le_d    = 1'b0;
         out_fe_d    = 1'b0;
         phase_d     = 1'b0;
         last_pix_d  = pix_last;
         state_d     = ST_FILL;
         wr_addr_d   = pix_last ? '0 : pix_addr + A_ONE;
         if (pix_last) begin
            len_d     = {1'b0, pix_addr} + L_ONE;
            fe_line_d = in_frame_end;
         end
         if ((pix_addr == LAST_ADDR) && !in_line_end && !in_frame_end) err_d = 1'b1;
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         len_q       <= '0;
         phase_q     <= 1'b0;
         last_pix_q  <= 1'b0;
         fe_line_q   <= 1'b0;
         err_q       <= 1'b0;
         rdy_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_fs_q    <= 1'b0;
         out_ls_q    <= 1'b0;
         out_le_q    <= 1'b0;
         out_fe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         len_q       <= len_d;
         phase_q     <= phase_d;
         last_pix_q  <= last_pix_d;
         fe_line_q   <= fe_line_d;
         err_q       <= err_d;
         rdy_en_q    <= 1'b1;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_fs_q    <= out_fs_d;
         out_ls_q    <= out_ls_d;
         out_le_q    <= out_le_d;
         out_fe_q    <= out_fe_d;
      end
   end

   assign in_ready        = in_ready_c;
   assign out_valid       = out_valid_q;
   assign out_data        = out_data_q;
   assign out_frame_start = out_fs_q;
   assign out_line_start  = out_ls_q;
   assign out_line_end    = out_le_q;
   assign out_frame_end   = out_fe_q;
   assign err_overflow    = err_q;

endmodule

// File: tb/tb_upsample_2x.sv
// Bench for upsample_2x: beat-level reference model plus directed and
// random frames. Honours UPSAMPLE_ZERO_INSERT_EN when it is defined.
module tb_upsample_2x;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
`ifdef UPSAMPLE_ZERO_INSERT_EN
   localparam bit ZI = 1'b1;
`else
   localparam bit ZI = 1'b0;
`endif

   typedef logic signed [DW-1:0] pix_t;
   typedef struct {
      pix_t d;
      logic fs, ls, le, fe;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready;
   logic [DW-1:0] in_data = '0;
   logic in_frame_start = 1'b0, in_line_end = 1'b0, in_frame_end = 1'b0;
   logic out_valid, out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic out_frame_start, out_line_start, out_line_end, out_frame_end, err_overflow;

   int errors = 0;
   int checks = 0;
   int rdy_mode = 0;
   int pat_i = 0;
   bit [3:0] pat = 4'b1001;
   beat_t exp_q[$];
   beat_t cap_q[$];
   bit stall_pend = 1'b0;
   pix_t stall_data;

   always #5 clk = ~clk;

   upsample_2x #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_frame_start(in_frame_start), .in_line_end(in_line_end), .in_frame_end(in_frame_end),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_frame_start(out_frame_start), .out_line_start(out_line_start),
      .out_line_end(out_line_end), .out_frame_end(out_frame_end),
      .err_overflow(err_overflow)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Expected beats for one input line: two output lines of 2N beats.
   function automatic void model_line(input pix_t px[$], input bit first_of_frame, input bit frame_end);
      int n;
      beat_t b;
      n = px.size();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < n; i++)
            for (int h = 0; h < 2; h++) begin
               b.d  = (ZI && (r == 1 || h == 1)) ? pix_t'(0) : px[i];
               b.fs = first_of_frame && r == 0 && i == 0 && h == 0;
               b.ls = (i == 0 && h == 0);
               b.le = (i == n - 1 && h == 1);
               b.fe = frame_end && r == 1 && i == n - 1 && h == 1;
               exp_q.push_back(b);
            end
   endfunction

   // Downstream ready pattern, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1: out_ready = 1'($urandom_range(0, 1));
         2: begin
            out_ready = pat[3 - pat_i];
            pat_i = (pat_i + 1) % 4;
         end
         default: out_ready = 1'b1;
      endcase
   end

   // Compare process: every handshaked beat against the model queue.
   always @(negedge clk) begin
      beat_t g, e;
      if (!rst_n) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            chk("stall_valid_held", longint'(out_valid), 1);
            chk("stall_data_held", longint'($signed(out_data)), longint'(stall_data));
         end
         stall_pend = 1'b0;
         if (out_valid && out_ready) begin
            g.d = $signed(out_data);
            g.fs = out_frame_start; g.ls = out_line_start;
            g.le = out_line_end; g.fe = out_frame_end;
            cap_q.push_back(g);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got d=%0d with no beat expected", g.d);
            end else begin
               e = exp_q.pop_front();
               if (g.d !== e.d || g.fs !== e.fs || g.ls !== e.ls || g.le !== e.le || g.fe !== e.fe) begin
                  errors++;
                  $display("FAIL beat_%0d: got d=%0d fs=%0b ls=%0b le=%0b fe=%0b, expected d=%0d fs=%0b ls=%0b le=%0b fe=%0b",
                           cap_q.size() - 1, g.d, g.fs, g.ls, g.le, g.fe, e.d, e.fs, e.ls, e.le, e.fe);
               end
            end
         end else if (out_valid) begin
            stall_pend = 1'b1;
            stall_data = $signed(out_data);
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_beat(input pix_t d, input bit fs, input bit le, input bit fe);
      int n;
      n = 0;
      in_valid = 1'b1; in_data = d;
      in_frame_start = fs; in_line_end = le; in_frame_end = fe;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 2000) break;
      end
      if (n > 2000) chk("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_frame_start = 1'b0; in_line_end = 1'b0; in_frame_end = 1'b0;
   endtask

   task automatic send_line(input pix_t px[$], input bit fs, input bit fe, input bit gaps);
      for (int i = 0; i < px.size(); i++) begin
         send_beat(px[i], fs && i == 0, i == px.size() - 1, fe && i == px.size() - 1);
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk(name, exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      pix_t px[$];
      int exp_d1[16];
      int exp_d3[4];
      int exp_d6[8];
      int cnt;

      if (ZI) begin
         exp_d1 = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
         exp_d3 = '{-7,0,0,0};
         exp_d6 = '{5,0,6,0, 0,0,0,0};
      end else begin
         exp_d1 = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
         exp_d3 = '{-7,-7,-7,-7};
         exp_d6 = '{5,5,6,6, 5,5,6,6};
      end

      // Reset values
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err", err_overflow, 0);
      chk("rst_markers", {out_frame_start, out_line_start, out_line_end, out_frame_end}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_rst", in_ready, 1);

      // Two-line frame, model pinned against literals first
      px = '{1, 2}; model_line(px, 1'b1, 1'b0);
      px = '{3, 4}; model_line(px, 1'b0, 1'b1);
      chk("model_size", exp_q.size(), 16);
      for (int i = 0; i < 16; i++) chk("model_d", exp_q[i].d, exp_d1[i]);
      chk("model_fs0", exp_q[0].fs, 1);
      chk("model_fe15", exp_q[15].fe, 1);
      cap_q.delete();
      px = '{1, 2}; send_line(px, 1'b1, 1'b0, 1'b0);
      px = '{3, 4}; send_line(px, 1'b0, 1'b1, 1'b0);
      wait_drain("drain_two_line");
      chk("t1_count", cap_q.size(), 16);
      for (int i = 0; i < 16 && i < cap_q.size(); i++) chk("t1_data", cap_q[i].d, exp_d1[i]);
      if (cap_q.size() == 16) begin
         chk("t1_first_fs", cap_q[0].fs, 1);
         chk("t1_last_fe", cap_q[15].fe, 1);
         chk("t1_le3", cap_q[3].le, 1);
         chk("t1_ls4", cap_q[4].ls, 1);
      end

      // Single pixel frame
      px = '{-7}; model_line(px, 1'b1, 1'b1);
      cap_q.delete();
      send_line(px, 1'b1, 1'b1, 1'b0);
      wait_drain("drain_single");
      chk("t2_count", cap_q.size(), 4);
      for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
         chk("t2_data", cap_q[i].d, exp_d3[i]);
         chk("t2_ls", cap_q[i].ls, (i % 2 == 0) ? 1 : 0);
         chk("t2_le", cap_q[i].le, (i % 2 == 1) ? 1 : 0);
      end

      // Stall pattern 1,0,0,1 on the output
      rdy_mode = 2;
      px = '{10, 20, 30}; model_line(px, 1'b1, 1'b1);
      send_line(px, 1'b1, 1'b1, 1'b0);
      wait_drain("drain_stall");
      rdy_mode = 0;

      // Overflow: 17-pixel line into a 16-deep buffer
      chk("err_before_ovf", err_overflow, 0);
      px.delete();
      for (int i = 0; i < 16; i++) px.push_back(pix_t'(100 + i));
      model_line(px, 1'b1, 1'b0);
      px = '{116}; model_line(px, 1'b0, 1'b1);
      cap_q.delete();
      px.delete();
      for (int i = 0; i < 17; i++) px.push_back(pix_t'(100 + i));
      for (int i = 0; i < 17; i++) send_beat(px[i], i == 0, i == 16, i == 16);
      wait_drain("drain_ovf");
      chk("err_after_ovf", err_overflow, 1);
      chk("ovf_count", cap_q.size(), 68);
      if (cap_q.size() == 68) begin
         cnt = 0;
         for (int i = 0; i < 32; i++) cnt += int'(cap_q[i].le);
         chk("ovf_le_in_first_line", cnt, 1);
         chk("ovf_le31", cap_q[31].le, 1);
         chk("ovf_p17_data", cap_q[64].d, 116);
         chk("ovf_p17_ls", cap_q[64].ls, 1);
      end

      // Reset pulse during replay
      px = '{7, 8, 9}; model_line(px, 1'b1, 1'b1);
      cap_q.delete();
      send_line(px, 1'b1, 1'b1, 1'b0);
      cnt = 0;
      while (cap_q.size() < 7 && cnt < 500) begin
         @(negedge clk);
         cnt++;
      end
      chk("reached_replay", cap_q.size() >= 7 ? 1 : 0, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_in_ready", in_ready, 0);
      chk("rst_mid_err", err_overflow, 0);
      exp_q.delete();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      px = '{11, -12}; model_line(px, 1'b1, 1'b1);
      send_line(px, 1'b1, 1'b1, 1'b0);
      wait_drain("drain_after_rst");

      // Zero-insert / nearest-neighbour pinned example
      px = '{5, 6}; model_line(px, 1'b1, 1'b1);
      cap_q.delete();
      send_line(px, 1'b1, 1'b1, 1'b0);
      wait_drain("drain_56");
      chk("t6_count", cap_q.size(), 8);
      for (int i = 0; i < 8 && i < cap_q.size(); i++) chk("t6_data", cap_q[i].d, exp_d6[i]);

      // Random frames with random backpressure, gaps and stray beats
      rdy_mode = 1;
      for (int f = 0; f < 25; f++) begin
         int nl;
         if ($urandom_range(0, 2) == 0) send_beat(pix_t'($urandom), 1'b0, 1'b0, 1'b0);
         nl = $urandom_range(1, 3);
         for (int l = 0; l < nl; l++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            px.delete();
            for (int i = 0; i < n; i++) px.push_back(pix_t'($urandom));
            model_line(px, l == 0, l == nl - 1);
            send_line(px, l == 0, l == nl - 1, 1'b1);
         end
      end
      wait_drain("drain_random");
      rdy_mode = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
